// File: rtl/uart_tx_if.sv
// Byte-in / serial-out handshake bundle for uart_tx.
interface uart_tx_if;
    logic [7:0] din;
    logic       tx_start;
    logic       tx_ready;
    logic       tx;
    logic       tx_busy;
    logic       tx_done;

    modport master (
        output din, tx_start,
        input  tx_ready, tx, tx_busy, tx_done
    );

    modport slave (
        input  din, tx_start,
        output tx_ready, tx, tx_busy, tx_done
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1/8N2 UART transmitter with a one-byte holding register in front of the shifter.
// Bit timing is 16 sub-ticks per bit, each sub-tick DIV clocks long.
module uart_tx #(
    parameter int unsigned CLOCK_SPEED = 50000000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned STOP_BITS   = 1
) (
    input  logic     clk,
    input  logic     rst,
    uart_tx_if.slave bus
);

    localparam int unsigned   DIV       = CLOCK_SPEED / (BAUD_RATE * 16);
    localparam int unsigned   CW        = $clog2(DIV);
    localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
    localparam logic [4:0]    STOP_LAST = 5'(16 * STOP_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] div_cnt_q, div_cnt_d;
    logic [4:0]    tick_cnt_q, tick_cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    hold_q, hold_d;
    logic          hold_full_q, hold_full_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          done_q, done_d;

    logic tick;
    logic accept;
    logic bit_end;
    logic stop_end;

    assign tick     = (div_cnt_q == DIV_LAST);
    assign accept   = bus.tx_start && ready_q;
    assign bit_end  = tick && (tick_cnt_q == 5'd15);
    assign stop_end = tick && (tick_cnt_q == STOP_LAST);

    always_comb begin
        state_d     = state_q;
        div_cnt_d   = tick ? '0 : div_cnt_q + CW'(1);
        tick_cnt_d  = tick ? tick_cnt_q + 5'd1 : tick_cnt_q;
        idx_d       = idx_q;
        shift_d     = shift_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_d        = tx_q;
        done_d      = 1'b0;

        // Acceptance and the hold->shift move are mutually exclusive:
        // accept needs an empty holding register, the move needs a full one.
        if (accept) begin
            hold_d      = bus.din;
            hold_full_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                tx_d       = 1'b1;
                div_cnt_d  = '0;
                tick_cnt_d = '0;
                if (hold_full_q) begin
                    shift_d     = hold_q;
                    hold_full_d = 1'b0;
                    idx_d       = '0;
                    state_d     = START;
                    tx_d        = 1'b0;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    tick_cnt_d = '0;
                    idx_d      = '0;
                    state_d    = DATA;
                    tx_d       = shift_q[0];
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    tick_cnt_d = '0;
                    shift_d    = {1'b0, shift_q[7:1]};
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        idx_d = idx_q + 3'd1;
                        tx_d  = shift_q[1];
                    end
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (stop_end) begin
                    done_d     = 1'b1;
                    tick_cnt_d = '0;
                    // Chain straight into the next frame when a byte is waiting.
                    if (hold_full_q) begin
                        shift_d     = hold_q;
                        hold_full_d = 1'b0;
                        idx_d       = '0;
                        div_cnt_d   = '0;
                        state_d     = START;
                        tx_d        = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        ready_d = ~hold_full_d;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            div_cnt_q   <= '0;
            tick_cnt_q  <= '0;
            idx_q       <= '0;
            shift_q     <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_q        <= 1'b1;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            div_cnt_q   <= div_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            idx_q       <= idx_d;
            shift_q     <= shift_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_q        <= tx_d;
            ready_q     <= ready_d;
            done_q      <= done_d;
        end
    end

    assign bus.tx       = tx_q;
    assign bus.tx_ready = ready_q;
    assign bus.tx_done  = done_q;
    assign bus.tx_busy  = (state_q != IDLE) || hold_full_q;

endmodule
